// File: rtl/buffer_ptr_ctrl.sv
// buffer_ptr_ctrl: wrap-at-DEPTH read/write pointer pair with occupancy, flags and sticky errors; PTR_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module buffer_ptr_ctrl #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  logic             wr_acc, rd_acc;
  logic [PTR_W-1:0] wr_nxt, rd_nxt;
  logic [PTR_W:0]   cnt_nxt;
  always_comb begin
    wr_acc  = wr_en & ~full;
    rd_acc  = rd_en & ~empty;
    wr_nxt  = ~wr_acc ? wr_ptr : (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    rd_nxt  = ~rd_acc ? rd_ptr : (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    cnt_nxt = count + {{PTR_W{1'b0}}, wr_acc} - {{PTR_W{1'b0}}, rd_acc};
  end
  // flags come from cnt_nxt so they always agree with the registered count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      full   <= cnt_nxt == (PTR_W+1)'(DEPTH);
      empty  <= cnt_nxt == '0;
      ovf    <= ovf | (wr_en & full);
      udf    <= udf | (rd_en & empty);
    end
  end
`ifdef PTR_ALMOST_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (clr) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= cnt_nxt >= (PTR_W+1)'(AF_LVL);
      almost_empty <= cnt_nxt <= (PTR_W+1)'(AE_LVL);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// tb_buffer_ptr_ctrl: directed checks of buffer_ptr_ctrl at DEPTH=3 (wrap, full/empty, errors, clr, async rst).
module tb_buffer_ptr_ctrl;
  logic       clk = 0, rst = 1, clr = 0, wr_en = 0, rd_en = 0;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, empty, ovf, udf, almost_full, almost_empty;
  int         total = 0, bad = 0;
  buffer_ptr_ctrl #(.DEPTH(3), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty),
    .ovf(ovf), .udf(udf), .almost_full(almost_full), .almost_empty(almost_empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input int wp, input int rp, input int c, input int o, input int u);
    check({tag, ".wr_ptr"}, wr_ptr, wp);
    check({tag, ".rd_ptr"}, rd_ptr, rp);
    check({tag, ".count"}, count, c);
    check({tag, ".full"}, full, c == 3);
    check({tag, ".empty"}, empty, c == 0);
    check({tag, ".ovf"}, ovf, o);
    check({tag, ".udf"}, udf, u);
`ifdef PTR_ALMOST_FLAGS_EN
    check({tag, ".af"}, almost_full, c >= 2);
    check({tag, ".ae"}, almost_empty, c <= 1);
`else
    check({tag, ".af"}, almost_full, 0);
    check({tag, ".ae"}, almost_empty, 0);
`endif
  endtask
  task automatic cyc(input logic w, input logic r, input logic c);
    wr_en = w;
    rd_en = r;
    clr   = c;
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
    clr   = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    st("reset", 0, 0, 0, 0, 0);
    cyc(1, 0, 0); st("w1", 1, 0, 1, 0, 0);
    cyc(1, 0, 0); st("w2", 2, 0, 2, 0, 0);
    cyc(1, 0, 0); st("w3", 0, 0, 3, 0, 0);
    cyc(1, 0, 0); st("ovf", 0, 0, 3, 1, 0);
    cyc(0, 0, 0); st("ovf_hold", 0, 0, 3, 1, 0);
    cyc(0, 1, 0); st("r1", 0, 1, 2, 1, 0);
    cyc(0, 1, 0); st("r2", 0, 2, 1, 1, 0);
    cyc(0, 1, 0); st("r3", 0, 0, 0, 1, 0);
    cyc(0, 1, 0); st("udf", 0, 0, 0, 1, 1);
    cyc(1, 0, 0); st("w4", 1, 0, 1, 1, 1);
    cyc(1, 1, 0); st("rw1", 2, 1, 1, 1, 1);
    cyc(1, 1, 0); st("rw2", 0, 2, 1, 1, 1);
    cyc(1, 1, 0); st("rw3", 1, 0, 1, 1, 1);
    cyc(1, 1, 0); st("rw4", 2, 1, 1, 1, 1);
    cyc(0, 0, 1); st("clr", 0, 0, 0, 0, 0);
    cyc(1, 1, 0); st("rw_empty", 1, 0, 1, 0, 1);
    cyc(1, 0, 0); st("w5", 2, 0, 2, 0, 1);
    cyc(1, 0, 0); st("w6", 0, 0, 3, 0, 1);
    cyc(1, 1, 0); st("rw_full", 0, 1, 2, 1, 1);
    cyc(1, 0, 1); st("clr_prio", 0, 0, 0, 0, 0);
    cyc(1, 0, 0); st("w7", 1, 0, 1, 0, 0);
    cyc(1, 0, 0); st("w8", 2, 0, 2, 0, 0);
    #2 rst = 1;
    #1 st("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 0, 0); st("post_rst", 1, 0, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_ptr_ctrl.md
# buffer_ptr_ctrl

Parametrised read/write pointer controller for the MAC operand and partial-sum buffers. It replaces the single free-running pointer with a write/read pointer pair that wraps at an arbitrary DEPTH, which need not be a power of two. It also tracks occupancy and raises full/empty flags plus sticky overflow/underflow errors. The surrounding buffer RAM is addressed directly by wr_ptr/rd_ptr.

## Interface
- DEPTH, 4, number of buffer entries; legal range 2..2^PTR_W
- PTR_W, 2, pointer width; 2^PTR_W >= DEPTH
- AF_LVL, DEPTH-1, almost-full threshold (count >= AF_LVL); used only with the macro
- AE_LVL, 1, almost-empty threshold (count <= AE_LVL); used only with the macro

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of pointers, count and errors
- wr_en  in  1  write request
- rd_en  in  1  read request
- wr_ptr  out  PTR_W  next entry to write
- rd_ptr  out  PTR_W  next entry to read
- count  out  PTR_W+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- ovf  out  1  sticky: write requested while full
- udf  out  1  sticky: read requested while empty
- almost_full  out  1  only with PTR_ALMOST_FLAGS_EN
- almost_empty  out  1  only with PTR_ALMOST_FLAGS_EN

## Operation
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0
  - ovf=0, udf=0
  - almost_full=0, almost_empty=1
- Acceptance is decided from registered flags only:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- wr_acc: wr_ptr advances by 1. rd_acc: rd_ptr advances by 1.
- Wrap: a pointer equal to DEPTH-1 goes to 0 and never reaches DEPTH..2^PTR_W-1.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - When full: the read is accepted and the write is rejected; ovf is set and count goes to DEPTH-1.
  - When empty: the write is accepted and the read is rejected; udf is set and count goes to 1.
- Rejected requests never move a pointer or count.
- ovf is set by wr_en & full. udf is set by rd_en & empty.
- Both stay set until rst or clr.
- clr has priority over wr_en/rd_en in the same cycle: all state returns to reset values, and the requests that cycle are ignored, with no error set.
- rst asserted mid-operation: state returns to reset values immediately, regardless of clk.
- Flags are registered and computed from the next count, so they are always consistent with count in the same cycle.
- Never combinational from wr_en/rd_en.

## Timing
- Single clock domain; all outputs registered.
- Latency:
  - pointers, count and flags reflect an accepted request one clock after the edge that samples it
  - back-to-back accepts every cycle are supported
- ovf/udf assert on the edge that samples the offending request.
- rst deassertion must be synchronous to clk externally; the first accept is possible on the first edge after deassertion.

## Configuration
- Macro: PTR_ALMOST_FLAGS_EN.
- Defined:
  - almost_full = (next count >= AF_LVL) and almost_empty = (next count <= AE_LVL), both registered
  - reset values 0 and 1 respectively
- Undefined: both ports exist but are tied to 0, and AF_LVL/AE_LVL are ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset check (DEPTH=3, PTR_W=2): assert rst mid-cycle with count=2.
  - Required: outputs go immediately to wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovf=0, udf=0.
- Non-power-of-two wrap (DEPTH=3, PTR_W=2): 3 writes, then 3 reads, then 1 write.
  - After the writes: wr_ptr 1,2,0 and full=1 at count=3.
  - After the reads: rd_ptr 1,2,0 and empty=1.
  - After the final write: wr_ptr=1, and the value 3 never appears on either pointer.
- Overflow: with full=1, pulse wr_en for 1 cycle.
  - Required: count stays 3, wr_ptr unchanged, ovf=1 from the next cycle and held until clr.
  - Same sequence for underflow on empty sets udf=1.
- Simultaneous access:
  - At count=1, wr_en=rd_en=1 for 4 cycles: count stays 1, both pointers advance 4 positions mod DEPTH.
  - At full, wr_en=rd_en=1: count goes to 2, ovf=1.
- Clear priority: at count=2, assert clr together with wr_en=1.
  - Required next cycle: count=0, wr_ptr=0, ovf=0, empty=1.
- With PTR_ALMOST_FLAGS_EN (DEPTH=4, AF_LVL=3, AE_LVL=1): fill 0→4.
  - almost_empty=1 at count 0,1 and 0 from count 2.
  - almost_full=1 from count 3.
  - Without the macro, both flags read 0 throughout.
